// File: rtl/alu_if.sv
// Operand/result handshake bundle for alu_seq: valid/ready on both the
// issue side and the result side, plus the registered result flags.
interface alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             negative;
  logic             overflow;

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, result, carry, zero, negative, overflow
  );

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, result, carry, zero, negative, overflow
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, bit-serial shifts/rotates,
// and an optional shift-add multiplier enabled by defining ALU_MUL_EN.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic  clk,
  input logic  rst_n,
  alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0] result_q;
  logic             carry_q, zero_q, negative_q, overflow_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [1:0]       shop;
  logic             accept, last_step, mul_op, multi;
  logic [SHW-1:0]   k;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] res_single;
  logic             c_single, v_single;
  logic [WIDTH-1:0] sh_step;
  logic             sh_out;
  logic [WIDTH-1:0] exec_res;
  logic             exec_c, exec_v;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;
  assign bus.overflow  = overflow_q;

  assign accept    = bus.in_valid && (state == IDLE);
  assign k         = bus.b[SHW-1:0];
  assign last_step = (cnt == CW'(1));
  assign multi     = mul_op || ((bus.sel[3:2] == 2'b10) && (k != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = multi ? EXEC : DONE;
      EXEC:    if (last_step) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle result; shifts by zero fall through here with a unchanged.
  always_comb begin
    sum_ext    = {1'b0, bus.a} + {1'b0, bus.b};
    diff_ext   = {1'b0, bus.a} - {1'b0, bus.b};
    res_single = '0;
    c_single   = 1'b0;
    v_single   = 1'b0;
    case (bus.sel)
      4'h0: begin
        res_single = sum_ext[WIDTH-1:0];
        c_single   = sum_ext[WIDTH];
        v_single   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'h1: begin
        res_single = diff_ext[WIDTH-1:0];
        c_single   = diff_ext[WIDTH];
        v_single   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_ext[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'h2: begin res_single = bus.a + WIDTH'(1); c_single = &bus.a;          end
      4'h3: begin res_single = bus.a - WIDTH'(1); c_single = (bus.a == '0);   end
      4'h4: res_single = bus.a & bus.b;
      4'h5: res_single = bus.a | bus.b;
      4'h6: res_single = bus.a ^ bus.b;
      4'h7: res_single = ~bus.a;
      4'h8, 4'h9, 4'hA, 4'hB: res_single = bus.a;
      4'hC: res_single = {{(WIDTH-1){1'b0}}, bus.a == bus.b};
      4'hD: res_single = {{(WIDTH-1){1'b0}}, bus.a <  bus.b};
      4'hE: res_single = {{(WIDTH-1){1'b0}}, bus.a >  bus.b};
      default: ;
    endcase
  end

  always_comb begin
    sh_step = shreg;
    sh_out  = 1'b0;
    case (shop)
      2'b00: {sh_out, sh_step} = {shreg, 1'b0};
      2'b01: {sh_step, sh_out} = {1'b0, shreg};
      2'b10: begin sh_step = {shreg[WIDTH-2:0], shreg[WIDTH-1]}; sh_out = shreg[WIDTH-1]; end
      default: begin sh_step = {shreg[0], shreg[WIDTH-1:1]}; sh_out = shreg[0]; end
    endcase
  end

`ifdef ALU_MUL_EN
  logic                 is_mul;
  logic [2*WIDTH-1:0]   acc, acc_next, mcand;
  logic [WIDTH-1:0]     mplr;

  assign mul_op   = (bus.sel == 4'hF);
  assign acc_next = acc + (mplr[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_mul <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
    end else if (accept) begin
      is_mul <= mul_op;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, bus.a};
      mplr   <= bus.b;
    end else if (state == EXEC && is_mul) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplr   <= mplr >> 1;
    end
  end

  assign exec_res = is_mul ? acc_next[WIDTH-1:0] : sh_step;
  assign exec_c   = is_mul ? |acc_next[2*WIDTH-1:WIDTH] : sh_out;
  assign exec_v   = is_mul && (|acc_next[2*WIDTH-1:WIDTH]);
`else
  assign mul_op   = 1'b0;
  assign exec_res = sh_step;
  assign exec_c   = sh_out;
  assign exec_v   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
      cnt        <= '0;
      shreg      <= '0;
      shop       <= '0;
    end else if (accept) begin
      shreg <= bus.a;
      shop  <= bus.sel[1:0];
      cnt   <= mul_op ? CW'(WIDTH) : CW'(k);
      if (!multi) begin
        result_q   <= res_single;
        carry_q    <= c_single;
        overflow_q <= v_single;
        zero_q     <= (res_single == '0);
        negative_q <= res_single[WIDTH-1];
      end
    end else if (state == EXEC) begin
      shreg <= sh_step;
      cnt   <= cnt - CW'(1);
      if (last_step) begin
        result_q   <= exec_res;
        carry_q    <= exec_c;
        overflow_q <= exec_v;
        zero_q     <= (exec_res == '0);
        negative_q <= exec_res[WIDTH-1];
      end
    end
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU with registered outputs and valid/ready handshakes on both sides. Successor to the 8-bit combinational ALU:
- WIDTH is generic.
- Shifts/rotates take a variable amount, iterated one bit per cycle.
- Optional shift-add multiplier.
- Drives a real signed-overflow flag.

Sits between an operand-issuing controller and a result consumer; one operation in flight at a time.

## Interface
- WIDTH, 8, operand/result width; power of two, >= 4
- SHW, $clog2(WIDTH), shift-amount field width (derived, not overridden)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept; high only in IDLE
- a, b  in  WIDTH each  operands (unsigned; signed view for overflow)
- sel  in  4  opcode
- out_valid  out  1  result/flags valid; held until out_ready
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- carry, zero, negative, overflow  out  1 each  registered flags

## Operation
- FSM states: IDLE, EXEC, DONE. Accept = in_valid && in_ready at a rising edge; a, b, sel captured.
- Single-cycle ops (all except shift/rotate with amount > 0 and MUL):
  - IDLE -> DONE at the accept edge.
  - Result and flags registered at that same edge.
- Opcodes:
  - 0000 ADD: carry = bit WIDTH of sum; overflow = signed overflow.
  - 0001 SUB a-b: carry = borrow (a<b unsigned); overflow = signed overflow.
  - 0010 INC: carry = (a == all-ones).
  - 0011 DEC: carry = (a == 0).
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOT a.
  - 1000 SHL, 1001 SHR logical, 1010 ROL, 1011 ROR:
    - Applied to a by k = b[SHW-1:0].
    - carry = last bit shifted/rotated out; 0 when k = 0.
  - 1100 EQ, 1101 LT unsigned, 1110 GT unsigned: result 1 if true else 0.
  - 1111 MUL: low WIDTH bits of a*b; carry = overflow = (high half != 0).
- Flags:
  - overflow = 0 for all ops except ADD, SUB, MUL.
  - carry = 0 for logic and compare ops.
  - zero = (result == 0); negative = result[WIDTH-1], for every op.
- Shift/rotate, k > 0: accept edge -> EXEC with counter = k. One bit per edge. DONE at the edge where the counter reaches 0.
- MUL: accept edge -> EXEC with counter = WIDTH. Shift-add over a 2*WIDTH accumulator, one multiplier bit per edge. DONE after WIDTH edges.
- DONE: out_valid = 1; result and flags stable. On out_valid && out_ready -> IDLE.
- No accept is possible in the cycle of result handoff; in_ready rises the cycle after.
- in_valid is ignored outside IDLE. a, b, sel may change freely after accept.
- Reset values:
  - result 0, carry 0, zero 0, negative 0, overflow 0, out_valid 0.
  - State IDLE, so in_ready = 1 while rst_n is low.
- Reset mid-operation: immediate return to the reset values; the operation is discarded with no output.

## Timing
- Single-cycle ops: accepted at edge N -> out_valid high from edge N.
- Shift/rotate, k >= 1: out_valid from edge N+k.
- MUL: out_valid from edge N+WIDTH.
- in_ready is combinational from state only; there is no path from in_valid to in_ready.
- Outputs change only on clk edges or asynchronously on reset.
- Back-to-back throughput for single-cycle ops: one op per 2 cycles with out_ready tied high.

## Configuration
- ALU_MUL_EN defined:
  - MUL as above.
  - Multiplier datapath and WIDTH-cycle EXEC path present.
- ALU_MUL_EN undefined:
  - Opcode 1111 is single-cycle.
  - result 0, carry 0, overflow 0, zero 1, negative 0.
  - No multiplier logic synthesised.

## Test plan
- ADD, WIDTH=8, a=0x7F, b=0x01 -> result 0x80, carry 0, overflow 1, negative 1, zero 0; out_valid high the cycle after accept.
- SUB a=0x10, b=0x20 -> result 0xF0, carry 1, overflow 0, negative 1. LT with same operands -> result 0x01.
- SHL a=0xC1, b=2 -> out_valid 2 cycles after accept, result 0x04, carry 1. ROR a=0x01, b=0 -> single cycle, result 0x01, carry 0.
- MUL with ALU_MUL_EN:
  - 12*10 -> 0x78, carry 0, out_valid 8 cycles after accept.
  - 0x10*0x10 -> 0x00, carry 1, overflow 1, zero 1.
- MUL without ALU_MUL_EN: 0x10*0x10 -> result 0x00, carry 0, overflow 0, zero 1, single cycle.
- Backpressure and reset:
  - out_ready low 5 cycles in DONE -> result and flags stable, in_ready 0, a pulsed in_valid is not accepted.
  - rst_n low mid-MUL -> all outputs 0 and in_ready 1 immediately; no out_valid after release.
